// File: rtl/arf_write_arbiter_pkg.sv
// arf_write_arbiter_pkg: shared widths and modular index helper for the writeback arbiter.
package arf_write_arbiter_pkg;
  localparam int NUM_REQ_DEF = 4;
  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;
  function automatic int wrap(input int i, input int n);
    return i % n;
  endfunction
endpackage

// File: rtl/arf_write_arbiter_if.sv
// arf_write_arbiter_if: requester handshake plus the two registered RAM write ports.
interface arf_write_arbiter_if
  import arf_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic                      we1;
  logic                      we2;
  logic [ADDR_W-1:0]         waddr1;
  logic [ADDR_W-1:0]         waddr2;
  logic [DATA_W-1:0]         wdata1;
  logic [DATA_W-1:0]         wdata2;
  logic                      busy;
  modport master (output req_valid, req_addr, req_data,
                  input  req_ready, we1, we2, waddr1, waddr2, wdata1, wdata2, busy);
  modport slave  (input  req_valid, req_addr, req_data,
                  output req_ready, we1, we2, waddr1, waddr2, wdata1, wdata2, busy);
endinterface

// File: rtl/arf_write_arbiter_rr_pick.sv
// arf_write_arbiter_rr_pick: rotating first-one finder starting at i_start.
module arf_write_arbiter_rr_pick
  import arf_write_arbiter_pkg::*;
#(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] i_mask,
  input  logic [W-1:0] i_start,
  output logic         o_found,
  output logic [W-1:0] o_idx
);
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int k = N - 1; k >= 0; k--)
      if (i_mask[wrap(int'(i_start) + k, N)]) begin
        o_found = 1'b1;
        o_idx   = W'(wrap(int'(i_start) + k, N));
      end
  end
endmodule

// File: rtl/arf_write_arbiter.sv
// arf_write_arbiter: round-robin scheduler of writeback requests onto two RAM write ports.
// Optional ARF_WARB_X0_DISCARD_EN: address-0 requests are acknowledged but never written.
module arf_write_arbiter
  import arf_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input logic               clk,
  input logic               reset,
  arf_write_arbiter_if.slave bus
);
  localparam int RW = $clog2(NUM_REQ);
  logic [RW-1:0]      r_rr;
  logic               r_we1;
  logic               r_we2;
  logic [ADDR_W-1:0]  r_waddr1;
  logic [ADDR_W-1:0]  r_waddr2;
  logic [DATA_W-1:0]  r_wdata1;
  logic [DATA_W-1:0]  r_wdata2;
  logic               r_busy;
  logic [NUM_REQ-1:0] w_valid;
  logic [NUM_REQ-1:0] w_zero;
  logic [NUM_REQ-1:0] w_same;
  logic [NUM_REQ-1:0] w_cand;
  logic [NUM_REQ-1:0] w_grant;
  logic               w_fa;
  logic               w_fb;
  logic [RW-1:0]      w_ia;
  logic [RW-1:0]      w_ib;
  logic [RW-1:0]      w_last;
  logic [RW-1:0]      w_rr_nxt;
  logic [ADDR_W-1:0]  w_addr_a;
  logic [ADDR_W-1:0]  w_addr_b;
  logic [DATA_W-1:0]  w_data_a;
  logic [DATA_W-1:0]  w_data_b;
  assign w_valid = reset ? '0 : bus.req_valid;
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cmp
    assign w_zero[g] = bus.req_addr[g*ADDR_W +: ADDR_W] == '0;
    assign w_same[g] = bus.req_addr[g*ADDR_W +: ADDR_W] == w_addr_a;
  end
`ifdef ARF_WARB_X0_DISCARD_EN
  assign w_cand = w_valid & ~w_zero;
`else
  assign w_cand = w_valid;
`endif
  arf_write_arbiter_rr_pick #(.N(NUM_REQ)) u_pick_a (
    .i_mask (w_cand),
    .i_start(r_rr),
    .o_found(w_fa),
    .o_idx  (w_ia)
  );
  // B excludes A and every requester sharing A's address, so the ports never collide
  arf_write_arbiter_rr_pick #(.N(NUM_REQ)) u_pick_b (
    .i_mask (w_cand & ~w_same),
    .i_start(r_rr),
    .o_found(w_fb),
    .o_idx  (w_ib)
  );
  assign w_addr_a = bus.req_addr[int'(w_ia)*ADDR_W +: ADDR_W];
  assign w_addr_b = bus.req_addr[int'(w_ib)*ADDR_W +: ADDR_W];
  assign w_data_a = bus.req_data[int'(w_ia)*DATA_W +: DATA_W];
  assign w_data_b = bus.req_data[int'(w_ib)*DATA_W +: DATA_W];
  always_comb begin
    w_grant = (w_fa ? NUM_REQ'(1) << w_ia : '0) | (w_fb ? NUM_REQ'(1) << w_ib : '0);
`ifdef ARF_WARB_X0_DISCARD_EN
    w_grant = w_grant | (w_valid & w_zero);
`endif
  end
  assign bus.req_ready = w_grant;
  always_comb begin
    w_last = r_rr;
    for (int k = 0; k < NUM_REQ; k++)
      if (w_grant[wrap(int'(r_rr) + k, NUM_REQ)]) w_last = RW'(wrap(int'(r_rr) + k, NUM_REQ));
    w_rr_nxt = |w_grant ? RW'(wrap(int'(w_last) + 1, NUM_REQ)) : r_rr;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr     <= '0;
      r_we1    <= 1'b0;
      r_we2    <= 1'b0;
      r_waddr1 <= '0;
      r_waddr2 <= '0;
      r_wdata1 <= '0;
      r_wdata2 <= '0;
      r_busy   <= 1'b0;
    end else begin
      r_rr   <= w_rr_nxt;
      r_we1  <= w_fa;
      r_we2  <= w_fb;
      r_busy <= |(w_valid & ~w_grant);
      if (w_fa) begin
        r_waddr1 <= w_addr_a;
        r_wdata1 <= w_data_a;
      end
      if (w_fb) begin
        r_waddr2 <= w_addr_b;
        r_wdata2 <= w_data_b;
      end
    end
  end
  // a write staged before reset must not reach the RAM during the reset cycle
  assign bus.we1    = r_we1 & ~reset;
  assign bus.we2    = r_we2 & ~reset;
  assign bus.waddr1 = r_waddr1;
  assign bus.waddr2 = r_waddr2;
  assign bus.wdata1 = r_wdata1;
  assign bus.wdata2 = r_wdata2;
  assign bus.busy   = r_busy;
endmodule

// File: tb/tb_arf_write_arbiter.sv
// tb_arf_write_arbiter: directed checks of grants, write ports, busy and reset behaviour.
module tb_arf_write_arbiter;
  import arf_write_arbiter_pkg::*;
  localparam int N  = 4;
  localparam int AW = ADDR_W_DEF;
  localparam int DW = DATA_W_DEF;
  logic clk;
  logic reset;
  int   pass_cnt;
  int   total_cnt;
  arf_write_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();
  arf_write_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );
  logic [DW-1:0] ram [1<<AW] = '{default: '0};
  always @(posedge clk) begin
    if (bus.we1) ram[bus.waddr1] <= bus.wdata1;
    if (bus.we2) ram[bus.waddr2] <= bus.wdata2;
  end
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic set_req(input int i, input logic v, input int a, input int d);
    bus.req_valid[i]          = v;
    bus.req_addr[i*AW +: AW]  = AW'(a);
    bus.req_data[i*DW +: DW]  = DW'(d);
  endtask
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
    else pass_cnt++;
  endtask
  task automatic do_reset();
    bus.req_valid = '0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, i + 1, i + 1);
    #1;
    chk("reset_ready", 64'(bus.req_ready), 64'h0);
    step();
    step();
    chk("reset_ready2", 64'(bus.req_ready), 64'h0);
    chk("reset_we", {62'h0, bus.we1, bus.we2}, 64'h0);
    chk("reset_waddr", {bus.waddr1, bus.waddr2}, 64'h0);
    chk("reset_wdata", {bus.wdata1, bus.wdata2}, 64'h0);
    chk("reset_busy", 64'(bus.busy), 64'h0);
    bus.req_valid = '0;
    reset = 1'b0;
    step();
    chk("idle_we", {62'h0, bus.we1, bus.we2}, 64'h0);
    chk("idle_busy", 64'(bus.busy), 64'h0);
  endtask
  task automatic test_pair();
    do_reset();
    set_req(0, 1'b1, 3, 'h11);
    set_req(1, 1'b1, 5, 'h22);
    #1;
    chk("pair_ready", 64'(bus.req_ready), 64'h3);
    step();
    bus.req_valid = '0;
    chk("pair_we", {62'h0, bus.we1, bus.we2}, 64'h3);
    chk("pair_waddr1", 64'(bus.waddr1), 64'd3);
    chk("pair_wdata1", 64'(bus.wdata1), 64'h11);
    chk("pair_waddr2", 64'(bus.waddr2), 64'd5);
    chk("pair_wdata2", 64'(bus.wdata2), 64'h22);
    chk("pair_busy", 64'(bus.busy), 64'h0);
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 20 + i, i);
    #1;
    chk("pair_rr2_ready", 64'(bus.req_ready), 64'hc);
    step();
    bus.req_valid = '0;
    step();
  endtask
  task automatic test_same_addr();
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 7, i + 1);
    for (int c = 0; c < N; c++) begin
      #1;
      chk($sformatf("same_ready%0d", c), 64'(bus.req_ready), 64'(1 << c));
      step();
      bus.req_valid[c] = 1'b0;
      chk($sformatf("same_we%0d", c), {62'h0, bus.we1, bus.we2}, 64'h2);
      chk($sformatf("same_wdata%0d", c), 64'(bus.wdata1), 64'(c + 1));
      chk($sformatf("same_busy%0d", c), 64'(bus.busy), (c < N - 1) ? 64'h1 : 64'h0);
    end
    step();
    chk("same_ram7", 64'(ram[7]), 64'd4);
  endtask
  task automatic test_alternate();
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, i + 1, 'h40 + i);
    for (int c = 0; c < N; c++) begin
      #1;
      chk($sformatf("alt_ready%0d", c), 64'(bus.req_ready), (c % 2 == 0) ? 64'h3 : 64'hc);
      step();
      chk($sformatf("alt_waddr%0d", c), {bus.waddr1, bus.waddr2},
          (c % 2 == 0) ? {AW'(1), AW'(2)} : {AW'(3), AW'(4)});
    end
    bus.req_valid = '0;
    step();
  endtask
  task automatic test_b_skip();
    do_reset();
    set_req(0, 1'b1, 3, 'h31);
    set_req(1, 1'b1, 3, 'h32);
    set_req(2, 1'b1, 6, 'h33);
    #1;
    chk("skip_ready", 64'(bus.req_ready), 64'h5);
    step();
    bus.req_valid[0] = 1'b0;
    bus.req_valid[2] = 1'b0;
    chk("skip_waddr", {bus.waddr1, bus.waddr2}, {AW'(3), AW'(6)});
    chk("skip_busy", 64'(bus.busy), 64'h1);
    #1;
    chk("skip_ready2", 64'(bus.req_ready), 64'h2);
    step();
    bus.req_valid = '0;
    step();
    chk("skip_ram3", 64'(ram[3]), 64'h32);
  endtask
  task automatic test_zero_discard();
    do_reset();
    set_req(0, 1'b1, 0, 'h55);
    set_req(1, 1'b1, 4, 'h66);
    set_req(2, 1'b1, 9, 'h77);
    #1;
`ifdef ARF_WARB_X0_DISCARD_EN
    chk("x0_ready", 64'(bus.req_ready), 64'h7);
    step();
    bus.req_valid = '0;
    chk("x0_waddr", {bus.waddr1, bus.waddr2}, {AW'(4), AW'(9)});
    step();
    chk("x0_ram0", 64'(ram[0]), 64'h0);
`else
    chk("x0_ready", 64'(bus.req_ready), 64'h3);
    step();
    bus.req_valid = '0;
    chk("x0_waddr", {bus.waddr1, bus.waddr2}, {AW'(0), AW'(4)});
    step();
    chk("x0_ram0", 64'(ram[0]), 64'h55);
`endif
    step();
  endtask
  task automatic test_reset_mid();
    do_reset();
    set_req(0, 1'b1, 10, 'haa);
    #1;
    chk("mid_ready", 64'(bus.req_ready), 64'h1);
    step();
    bus.req_valid = '0;
    chk("mid_we_staged", 64'(bus.we1), 64'h1);
    reset = 1'b1;
    #1;
    chk("mid_we_gated", {62'h0, bus.we1, bus.we2}, 64'h0);
    step();
    reset = 1'b0;
    #1;
    chk("mid_we_after", {62'h0, bus.we1, bus.we2}, 64'h0);
    chk("mid_ram10", 64'(ram[10]), 64'h0);
  endtask
  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    reset = 1'b1;
    bus.req_valid = '0;
    bus.req_addr = '0;
    bus.req_data = '0;
    test_reset();
    test_pair();
    test_same_addr();
    test_alternate();
    test_b_skip();
    test_zero_discard();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/arf_write_arbiter.md
# arf_write_arbiter

Schedules register-file writeback traffic from NUM_REQ independent writeback requesters onto the two write ports of the 4-read/2-write architectural register RAM. Each cycle it grants at most two requests, never two to the same address, in round-robin order, and drives registered we1/we2 ports. It sits between the commit/writeback stage and the register RAM, replacing ad-hoc port muxing.

## Interface
Parameters:
- NUM_REQ, 4: number of writeback requesters (2..8).
- ADDR_W, `REG_SEL: register address width.
- DATA_W, `DATA_LEN: register data width.

Ports (all active-high):
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  request valid, one bit per requester.
- req_addr  in  NUM_REQ*ADDR_W  flattened addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_data  in  NUM_REQ*DATA_W  flattened write data, same packing.
- req_ready  out  NUM_REQ  grant; the request is consumed when valid&ready.
- we1, we2  out  1  RAM write enables, registered.
- waddr1, waddr2  out  ADDR_W  RAM write addresses, registered.
- wdata1, wdata2  out  DATA_W  RAM write data, registered.
- busy  out  1  registered; high when any request was left ungranted last cycle.

## Operation
- Round-robin pointer rr (log2 NUM_REQ bits).
- Pick A: the first requester with req_valid=1, scanning rr, rr+1, … mod NUM_REQ.
- Pick B: the first valid requester after A in the same scan order whose address differs from A's address.
- Grants:
  - req_ready is combinational from req_valid, req_addr and rr.
  - It is asserted only for A and B.
  - req_ready is never asserted without the matching req_valid.
- Same-address requests in one cycle: only the earlier one in scan order is granted; the other waits at least one cycle, so its write lands later and its value persists.
- Pointer update:
  - rr <= (last granted index + 1) mod NUM_REQ.
  - rr is unchanged when nothing is granted.
- Ungranted requesters must hold valid/addr/data stable until granted.
- Output register, next cycle:
  - we1 = grant A exists, with waddr1/wdata1 taken from A.
  - we2 = grant B exists, with waddr2/wdata2 taken from B.
  - When a port is not used, its address and data hold their previous values.
- Guarantee: when both we1 and we2 are high, waddr1 != waddr2.
- busy <= (valid requests) & ~(granted) is nonzero.

## Timing
- Reset values: rr=0; we1=we2=0; waddr1/2=0; wdata1/2=0; busy=0.
- While reset=1, req_ready=0.
- Reset asserted mid-operation: the next edge clears the output stage, and any write staged but not yet driven is discarded.
- Latency:
  - Handshake in cycle N.
  - we/waddr/wdata are valid in cycle N+1.
  - The RAM contents update at the end of N+1.
  - A read in cycle N+2 returns the new value.
- Throughput: 2 writes/cycle when at least two distinct addresses are pending.
- Worst-case wait for any requester: ceil(NUM_REQ/2) cycles when it is continuously valid, and NUM_REQ cycles when all requesters target one address.

## Configuration
- ARF_WARB_X0_DISCARD_EN:
  - Defined: a request with address 0 is granted (ready=1) but never reaches a write port.
    - It consumes no write port, so pick B may be a third requester.
    - The zero register is never written.
  - Undefined: address 0 is treated like any other address.

## Structure
- ADDR_W/DATA_W defaults come from `REG_SEL/`DATA_LEN in constants.vh.
- Add no new global defines beyond ARF_WARB_X0_DISCARD_EN, which is set in the top-level build defines.
- Sub-module rr_pick: rotating first-one finder.
  - Inputs: request mask and start index.
  - Outputs: found flag and index.
  - Instantiated twice: once for A, and once for B with A and same-address requesters masked out.

## Test plan
- Reset then idle: all outputs are 0 and req_ready=0 during reset; rr=0 afterwards.
- Requesters 0,1 valid with addr 3,5, data 0x11,0x22:
  - Same cycle: ready=0011.
  - Next cycle: we1=1 waddr1=3 wdata1=0x11, we2=1 waddr2=5 wdata2=0x22.
  - Then rr=2.
- All four valid with addr 7, data 1,2,3,4, held:
  - Exactly one grant per cycle, order 0,1,2,3.
  - Final RAM[7]=4.
  - busy is high for 3 cycles.
- All four valid with distinct addresses for 4 cycles, with requests re-presented:
  - Grants alternate 0011, 1100, 0011, 1100.
  - No requester waits more than 2 cycles.
- With ARF_WARB_X0_DISCARD_EN defined, requesters 0,1,2 at addr 0,4,9:
  - ready=0111.
  - Next cycle: waddr1=4, waddr2=9.
  - Address 0 is never written.
  - Without the macro, ready=0011 and waddr1=0.
- Reset asserted in the cycle after a handshake: we1/we2 are 0 in the following cycle, and the RAM is unchanged.
